axis_sync_inserter: RTL and testbench

//  Downstream stage of the generic width converter. Consumes its M-bit symbol stream (tdata/tfirst/tvalid,

---
 rtl/axis_sync_inserter.sv | 149 ++++++++++++++
 tb/tb_axis_sync_inserter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sync_inserter.sv
// axis_sync_inserter: prepends a fixed SYNC_LEN-symbol sync word to every
// frame of FRAME_LEN payload symbols and emits a registered M-bit stream.
// Symbols seen outside a frame are dropped and counted. A tfirst arriving
// inside a frame flags frame_err and restarts with a fresh sync word.
//
// Build option: define AXIS_SYNC_INS_GRAY_EN to Gray-code payload symbols
// on load (out = d ^ (d >> 1)). Sync symbols are always sent raw.
//
// Handshake: a symbol moves across an interface in the cycle where both
// tvalid and tnext are high at the rising edge. s_axis_tnext is a
// combinational acknowledgement of the current input symbol. m_axis_tnext
// is the downstream acknowledgement of the current output symbol. While
// m_axis_tvalid is high and m_axis_tnext is low, the output data and tfirst
// are held stable.
module axis_sync_inserter #(
  parameter int M = 3,
  parameter int SYNC_LEN = 4,
  parameter logic [SYNC_LEN*M-1:0] SYNC_WORD = 12'o7061,
  parameter int FRAME_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] s_axis_tdata,
  input  logic         s_axis_tfirst,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tnext,
  input  logic         m_axis_tnext,
  output logic [M-1:0] m_axis_tdata,
  output logic         m_axis_tfirst,
  output logic         m_axis_tvalid,
  output logic         frame_err,
  output logic [15:0]  drop_count,
  output logic [1:0]   state_dbg
);

  localparam int SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SW-1:0] SIDX_LAST = SW'(SYNC_LEN - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] sidx;
  logic [PW-1:0] pcnt;
  logic          slot_free;
  logic          data_ok;
  logic [M-1:0]  payload;
  logic [M-1:0]  sync_sym;
  logic [M-1:0]  sync_tab [SYNC_LEN];

  assign state_dbg = state;

  // The sync word is split into symbols, most significant symbol first.
  for (genvar g = 0; g < SYNC_LEN; g++) begin : g_sync_tab
    assign sync_tab[g] = SYNC_WORD[(SYNC_LEN-1-g)*M +: M];
  end
  assign sync_sym = sync_tab[sidx];

`ifdef AXIS_SYNC_INS_GRAY_EN
  assign payload = s_axis_tdata ^ (s_axis_tdata >> 1);
`else
  assign payload = s_axis_tdata;
`endif

  // The output register can take a new symbol when it is empty or being drained.
  assign slot_free = !m_axis_tvalid || m_axis_tnext;
  // The first payload symbol must carry tfirst; every later one must not.
  assign data_ok   = (pcnt == '0) ? s_axis_tfirst : !s_axis_tfirst;

  // Input acknowledge: drop non-frame symbols in HUNT, accept payload in DATA.
  always_comb begin
    s_axis_tnext = 1'b0;
    if (rst) begin
      case (state)
        HUNT:    s_axis_tnext = s_axis_tvalid && !s_axis_tfirst;
        DATA:    s_axis_tnext = s_axis_tvalid && slot_free && data_ok;
        default: s_axis_tnext = 1'b0;
      endcase
    end
  end

  // Frame FSM with output slot, error pulse and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      sidx          <= '0;
      pcnt          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tfirst <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_err     <= 1'b0;
      drop_count    <= '0;
    end else begin
      frame_err <= 1'b0;
      // A drained slot empties unless something below reloads it.
      if (slot_free) m_axis_tvalid <= 1'b0;
      case (state)
        HUNT: begin
          if (s_axis_tvalid) begin
            if (s_axis_tfirst) begin
              state <= SYNC;
              sidx  <= '0;
            end else if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
        end
        SYNC: begin
          if (slot_free) begin
            m_axis_tdata  <= sync_sym;
            m_axis_tfirst <= (sidx == '0);
            m_axis_tvalid <= 1'b1;
            if (sidx == SIDX_LAST) begin
              state <= DATA;
              pcnt  <= '0;
            end else begin
              sidx <= sidx + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_axis_tnext) begin
            m_axis_tdata  <= payload;
            m_axis_tfirst <= 1'b0;
            m_axis_tvalid <= 1'b1;
            if (pcnt == PCNT_LAST) begin
              state <= HUNT;
              pcnt  <= '0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end else if (s_axis_tvalid && s_axis_tfirst && (pcnt != '0)) begin
            // Truncated frame: leave the new tfirst symbol waiting and resync.
            frame_err <= 1'b1;
            state     <= SYNC;
            sidx      <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sync_inserter.sv
// Testbench for axis_sync_inserter: cycle table for the basic frame, hand
// sequences for stall / error / reset cases, and a randomized stream checked
// against a symbol-level reference model.
module tb_axis_sync_inserter;

  localparam int M = 3;
  localparam int SYNC_LEN = 4;
  localparam logic [SYNC_LEN*M-1:0] SYNC_WORD = 12'o7061;
  localparam int FRAME_LEN = 4;
  localparam int W = M + 1;

  logic         clk;
  logic         rst;
  logic [M-1:0] s_axis_tdata;
  logic         s_axis_tfirst;
  logic         s_axis_tvalid;
  logic         s_axis_tnext;
  logic         m_axis_tnext;
  logic [M-1:0] m_axis_tdata;
  logic         m_axis_tfirst;
  logic         m_axis_tvalid;
  logic         frame_err;
  logic [15:0]  drop_count;
  logic [1:0]   state_dbg;

  axis_sync_inserter #(
    .M(M), .SYNC_LEN(SYNC_LEN), .SYNC_WORD(SYNC_WORD), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tfirst(s_axis_tfirst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tnext(s_axis_tnext),
    .m_axis_tnext(m_axis_tnext), .m_axis_tdata(m_axis_tdata),
    .m_axis_tfirst(m_axis_tfirst), .m_axis_tvalid(m_axis_tvalid),
    .frame_err(frame_err), .drop_count(drop_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] stim_q[$];   // {tfirst, tdata} input symbols
  logic [W-1:0] exp_q[$];    // {tfirst, tdata} expected output symbols
  logic [W-1:0] cap_q[$];    // captured output transfers
  int exp_drops;
  int exp_errs;
  int err_seen = 0;

  // Output monitor: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && m_axis_tvalid && m_axis_tnext) cap_q.push_back({m_axis_tfirst, m_axis_tdata});
    if (rst && frame_err) err_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [M-1:0] pay(input logic [M-1:0] d);
`ifdef AXIS_SYNC_INS_GRAY_EN
    return d ^ (d >> 1);
`else
    return d;
`endif
  endfunction

  function automatic logic [M-1:0] sync_symbol(input int i);
    logic [SYNC_LEN*M-1:0] w;
    w = SYNC_WORD;
    return w[(SYNC_LEN-1-i)*M +: M];
  endfunction

  // Reference model over the ordered list of input symbols.
  task automatic build_expected();
    bit in_frame = 0;
    int cnt = 0;
    exp_q.delete();
    exp_drops = 0;
    exp_errs = 0;
    foreach (stim_q[k]) begin
      logic fst;
      logic [M-1:0] d;
      {fst, d} = stim_q[k];
      if (fst) begin
        if (in_frame) exp_errs++;
        for (int i = 0; i < SYNC_LEN; i++) exp_q.push_back({(i == 0), sync_symbol(i)});
        in_frame = 1;
        cnt = 0;
      end
      if (!in_frame) begin
        exp_drops++;
      end else begin
        exp_q.push_back({1'b0, pay(d)});
        cnt++;
        if (cnt == FRAME_LEN) in_frame = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;
    s_axis_tdata = '0;
    m_axis_tnext = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cap_q.delete();
    err_seen = 0;
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_len"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_sym%0d", tag, i), cap_q[i], exp_q[i]);
    chk({tag, "_drops"}, drop_count, exp_drops);
    chk({tag, "_errs"}, err_seen, exp_errs);
  endtask

  // Drives stim_q to completion (optionally with random gaps and backpressure).
  task automatic run_stream(input string tag, input bit rnd);
    int budget = 0;
    bit presenting = 0;
    build_expected();
    while (stim_q.size() > 0 && budget < 4000) begin
      m_axis_tnext = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!presenting) presenting = !rnd || ($urandom_range(0, 2) != 0);
      s_axis_tvalid = presenting;
      {s_axis_tfirst, s_axis_tdata} = stim_q[0];
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tnext) begin
        void'(stim_q.pop_front());
        presenting = 0;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    chk({tag, "_timeout"}, (budget >= 4000), 0);
    stim_q.delete();
    s_axis_tvalid = 1'b0;
    m_axis_tnext = 1'b1;
    repeat (SYNC_LEN + FRAME_LEN + 4) begin
      @(posedge clk);
      #1;
    end
    compare_stream(tag);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic         vld;
    logic         fst;
    logic [M-1:0] dat;
    logic         rdy;
    logic         exp_snext;
    logic         exp_mvld;
    logic [M-1:0] exp_mdat;
    logic         exp_mfst;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Two stray symbols, then frame 5,3,2,4 back-to-back.
    vecs[0]  = '{1, 0, 3'd1, 1, 1, 0, 3'd0, 0};
    vecs[1]  = '{1, 0, 3'd2, 1, 1, 0, 3'd0, 0};
    vecs[2]  = '{1, 1, 3'd5, 1, 0, 0, 3'd0, 0};
    vecs[3]  = '{1, 1, 3'd5, 1, 0, 1, 3'd7, 1};
    vecs[4]  = '{1, 1, 3'd5, 1, 0, 1, 3'd0, 0};
    vecs[5]  = '{1, 1, 3'd5, 1, 0, 1, 3'd6, 0};
    vecs[6]  = '{1, 1, 3'd5, 1, 0, 1, 3'd1, 0};
    vecs[7]  = '{1, 1, 3'd5, 1, 1, 1, pay(3'd5), 0};
    vecs[8]  = '{1, 0, 3'd3, 1, 1, 1, pay(3'd3), 0};
    vecs[9]  = '{1, 0, 3'd2, 1, 1, 1, pay(3'd2), 0};
    vecs[10] = '{1, 0, 3'd4, 1, 1, 1, pay(3'd4), 0};
    vecs[11] = '{0, 0, 3'd0, 1, 0, 0, 3'd0, 0};

    // Reset state, with an input symbol that must not be acknowledged.
    rst = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tfirst = 1'b0;
    s_axis_tdata = 3'd2;
    m_axis_tnext = 1'b1;
    #2;
    chk("rst_snext", s_axis_tnext, 0);
    chk("rst_mvld", m_axis_tvalid, 0);
    chk("rst_mdat", m_axis_tdata, 0);
    chk("rst_mfst", m_axis_tfirst, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_drops", drop_count, 0);
    do_reset();

    // Cycle-accurate table: drops then a full frame at full rate.
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = vecs[i].vld;
      s_axis_tfirst = vecs[i].fst;
      s_axis_tdata  = vecs[i].dat;
      m_axis_tnext  = vecs[i].rdy;
      #1;
      chk($sformatf("tbl%0d_snext", i), s_axis_tnext, vecs[i].exp_snext);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_mvld", i), m_axis_tvalid, vecs[i].exp_mvld);
      if (vecs[i].exp_mvld) begin
        chk($sformatf("tbl%0d_mdat", i), m_axis_tdata, vecs[i].exp_mdat);
        chk($sformatf("tbl%0d_mfst", i), m_axis_tfirst, vecs[i].exp_mfst);
      end
    end
    chk("tbl_drops", drop_count, 2);
    chk("tbl_errs", err_seen, 0);

    // Truncated frame 5,3 followed by frame 6,1,1,1.
    do_reset();
    stim_q = '{{1'b1, 3'd5}, {1'b0, 3'd3}, {1'b1, 3'd6}, {1'b0, 3'd1}, {1'b0, 3'd1}, {1'b0, 3'd1}};
    run_stream("trunc", 0);

    // Downstream stall for three cycles while the sync word goes out.
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tfirst = 1'b1;
    s_axis_tdata = 3'd5;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    m_axis_tnext = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_snext", i), s_axis_tnext, 0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_mvld", i), m_axis_tvalid, 1);
      chk($sformatf("stall%0d_mdat", i), m_axis_tdata, 7);
      chk($sformatf("stall%0d_mfst", i), m_axis_tfirst, 1);
    end
    stim_q = '{{1'b1, 3'd5}, {1'b0, 3'd3}, {1'b0, 3'd2}, {1'b0, 3'd4}};
    run_stream("stall", 0);

    // Asynchronous reset in the middle of the payload, then a clean frame.
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tfirst = 1'b1;
    s_axis_tdata = 3'd5;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    s_axis_tfirst = 1'b0;
    s_axis_tdata = 3'd3;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mvld", m_axis_tvalid, 0);
    chk("arst_mdat", m_axis_tdata, 0);
    chk("arst_mfst", m_axis_tfirst, 0);
    chk("arst_snext", s_axis_tnext, 0);
    do_reset();
    stim_q = '{{1'b1, 3'd5}, {1'b0, 3'd3}, {1'b0, 3'd2}, {1'b0, 3'd4}};
    run_stream("restart", 0);

    // Randomized stream with gaps, stray symbols, truncated frames, backpressure.
    for (int rep = 0; rep < 4; rep++) begin
      do_reset();
      for (int f = 0; f < 12; f++) begin
        int r;
        int len;
        r = $urandom_range(0, 9);
        if (r < 2) begin
          for (int j = 0; j < $urandom_range(1, 2); j++) stim_q.push_back({1'b0, 3'($urandom_range(0, 7))});
        end
        len = (r == 9) ? $urandom_range(1, FRAME_LEN - 1) : FRAME_LEN;
        for (int j = 0; j < len; j++) stim_q.push_back({(j == 0), 3'($urandom_range(0, 7))});
      end
      run_stream($sformatf("rand%0d", rep), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
